// File: rtl/gcm_job_scheduler.sv
// Round-robin job scheduler that time-shares one gcm_aes core among NUM_REQ
// requesters: arbitrate, latch operands, launch the core, collect the
// ciphertext and tag (or time out), and hand the result back over valid/ready.
module gcm_job_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*96-1:0]        i_iv,
  input  logic [NUM_REQ*128-1:0]       i_key,
  input  logic [NUM_REQ*128-1:0]       i_pt,
  input  logic [NUM_REQ*128-1:0]       i_aad,
  input  logic [NUM_REQ-1:0]           i_aad_en,
  output logic [NUM_REQ-1:0]           o_gnt,
  output logic                         o_core_new,
  output logic [95:0]                  o_core_iv,
  output logic [127:0]                 o_core_key,
  output logic [127:0]                 o_core_pt,
  output logic [127:0]                 o_core_aad,
  output logic [63:0]                  o_core_pt_size,
  output logic [63:0]                  o_core_aad_size,
  input  logic                         i_core_cp_ready,
  input  logic [127:0]                 i_core_cipher,
  input  logic                         i_core_tag_ready,
  input  logic [127:0]                 i_core_tag,
  output logic                         o_res_valid,
  input  logic                         i_res_ready,
  output logic [$clog2(NUM_REQ)-1:0]   o_res_id,
  output logic [127:0]                 o_res_cipher,
  output logic [127:0]                 o_res_tag,
  output logic                         o_res_err,
  output logic                         o_busy,
  output logic [CNT_W-1:0]             o_job_cnt
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [TO_W-1:0]   tcnt_q;
  logic              cp_got_q, tag_got_q, aad_en_q;
  logic [CNT_W-1:0]  job_cnt_q;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  int                arb_idx;
  logic              wait_first, cp_cap, tag_cap, cp_now, tag_now, timeout_hit, to_fail;

  // Round-robin search starting one past the last winner, wrapping modulo NUM_REQ
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    arb_idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      arb_idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!win_found && i_req[ID_W'(arb_idx)]) begin
        win_found = 1'b1;
        win_id    = ID_W'(arb_idx);
      end
    end
  end

  // First WAIT cycle masks core readies so leftovers from the previous job are dropped
  assign wait_first  = (tcnt_q == '0);
  assign cp_cap      = (state_q == S_WAIT) && !wait_first && i_core_cp_ready && !cp_got_q;
  assign tag_cap     = (state_q == S_WAIT) && !wait_first && i_core_tag_ready && !tag_got_q;
  assign cp_now      = cp_got_q | cp_cap;
  assign tag_now     = tag_got_q | tag_cap;
  assign timeout_hit = (tcnt_q == TO_W'(TIMEOUT_CYC - 1));

  // Next-state logic; a completion landing on the timeout cycle still counts as success
  always_comb begin
    state_d = state_q;
    to_fail = 1'b0;
    case (state_q)
      S_IDLE:   if (win_found) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (cp_got_q && tag_got_q) begin
          state_d = S_RESP;
        end else if (timeout_hit) begin
          state_d = S_RESP;
          to_fail = !(cp_now && tag_now);
        end
      end
      S_RESP:   if (i_res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, arbitration pointer, operand latches, capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= ID_W'(NUM_REQ - 1);
      gnt_q        <= '0;
      tcnt_q       <= '0;
      cp_got_q     <= 1'b0;
      tag_got_q    <= 1'b0;
      aad_en_q     <= 1'b0;
      job_cnt_q    <= '0;
      o_core_iv    <= '0;
      o_core_key   <= '0;
      o_core_pt    <= '0;
      o_core_aad   <= '0;
      o_res_id     <= '0;
      o_res_cipher <= '0;
      o_res_tag    <= '0;
      o_res_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            ptr_q      <= win_id;
            gnt_q      <= NUM_REQ'(1) << win_id;
            o_res_id   <= win_id;
            o_core_iv  <= i_iv[int'(win_id)*96 +: 96];
            o_core_key <= i_key[int'(win_id)*128 +: 128];
            o_core_pt  <= i_pt[int'(win_id)*128 +: 128];
            o_core_aad <= i_aad[int'(win_id)*128 +: 128];
            aad_en_q   <= i_aad_en[win_id];
          end
        end
        S_LAUNCH: begin
          tcnt_q       <= '0;
          cp_got_q     <= 1'b0;
          tag_got_q    <= 1'b0;
          o_res_cipher <= '0;
          o_res_tag    <= '0;
          o_res_err    <= 1'b0;
        end
        S_WAIT: begin
          tcnt_q <= tcnt_q + 1'b1;
          if (cp_cap) begin
            o_res_cipher <= i_core_cipher;
            cp_got_q     <= 1'b1;
          end
          if (tag_cap) begin
            o_res_tag <= i_core_tag;
            tag_got_q <= 1'b1;
          end
          if (to_fail) begin
            o_res_cipher <= '0;
            o_res_tag    <= '0;
            o_res_err    <= 1'b1;
          end
        end
        S_RESP: begin
          if (i_res_ready) job_cnt_q <= job_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_gnt           = gnt_q;
  assign o_core_new      = (state_q == S_LAUNCH);
  assign o_core_pt_size  = 64'd128;
  assign o_core_aad_size = aad_en_q ? 64'd128 : 64'd0;
  assign o_res_valid     = (state_q == S_RESP);
  assign o_busy          = (state_q != S_IDLE);
  assign o_job_cnt       = job_cnt_q;

endmodule

// File: tb/tb_gcm_job_scheduler.sv
// Directed bench for gcm_job_scheduler with a behavioural gcm_aes responder
// and a queue of expected results checked as each result is presented.
module tb_gcm_job_scheduler;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] i_req = '0;
  logic [NR*96-1:0]  i_iv = '0;
  logic [NR*128-1:0] i_key = '0;
  logic [NR*128-1:0] i_pt = '0;
  logic [NR*128-1:0] i_aad = '0;
  logic [NR-1:0] i_aad_en = '0;
  logic [NR-1:0] o_gnt;
  logic          o_core_new;
  logic [95:0]   o_core_iv;
  logic [127:0]  o_core_key, o_core_pt, o_core_aad;
  logic [63:0]   o_core_pt_size, o_core_aad_size;
  logic          core_cp_ready = 1'b0;
  logic [127:0]  core_cipher = '0;
  logic          core_tag_ready = 1'b0;
  logic [127:0]  core_tag = '0;
  logic          o_res_valid;
  logic          i_res_ready = 1'b0;
  logic [1:0]    o_res_id;
  logic [127:0]  o_res_cipher, o_res_tag;
  logic          o_res_err, o_busy;
  logic [15:0]   o_job_cnt;

  gcm_job_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYC(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_iv(i_iv), .i_key(i_key),
    .i_pt(i_pt), .i_aad(i_aad), .i_aad_en(i_aad_en), .o_gnt(o_gnt),
    .o_core_new(o_core_new), .o_core_iv(o_core_iv), .o_core_key(o_core_key),
    .o_core_pt(o_core_pt), .o_core_aad(o_core_aad),
    .o_core_pt_size(o_core_pt_size), .o_core_aad_size(o_core_aad_size),
    .i_core_cp_ready(core_cp_ready), .i_core_cipher(core_cipher),
    .i_core_tag_ready(core_tag_ready), .i_core_tag(core_tag),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_id(o_res_id),
    .o_res_cipher(o_res_cipher), .o_res_tag(o_res_tag), .o_res_err(o_res_err),
    .o_busy(o_busy), .o_job_cnt(o_job_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [127:0] c;
    logic [127:0] t;
    logic         e;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  // Core responder settings: ready delays counted in cycles after o_core_new
  int           cp_dly = 2, tag_dly = 2;
  bit           stale = 1'b0, junk = 1'b0;
  logic [127:0] cp_val = '0, tag_val = '0;
  int           mcnt = 100;

  // Behavioural core: cipher = cp_val ^ key, tag = tag_val ^ pt
  always @(negedge clk) begin
    core_cp_ready  = 1'b0;
    core_tag_ready = 1'b0;
    core_cipher    = '0;
    core_tag       = '0;
    if (o_core_new) mcnt = 0;
    else mcnt++;
    if (stale && mcnt == 1) begin
      core_cp_ready  = 1'b1;
      core_tag_ready = 1'b1;
      core_cipher    = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
      core_tag       = 128'hbad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0;
    end
    if (mcnt == cp_dly) begin
      core_cp_ready = 1'b1;
      core_cipher   = cp_val ^ o_core_key;
    end else if (junk && mcnt == cp_dly + 1) begin
      core_cp_ready = 1'b1;
      core_cipher   = ~(cp_val ^ o_core_key);
    end
    if (mcnt == tag_dly) begin
      core_tag_ready = 1'b1;
      core_tag       = tag_val ^ o_core_pt;
    end else if (junk && mcnt == tag_dly + 1) begin
      core_tag_ready = 1'b1;
      core_tag       = ~(tag_val ^ o_core_pt);
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic reset_checks(input string pfx);
    chk({pfx, "_busy"}, o_busy, 0);
    chk({pfx, "_gnt"}, o_gnt, 0);
    chk({pfx, "_core_new"}, o_core_new, 0);
    chk({pfx, "_res_valid"}, o_res_valid, 0);
    chk({pfx, "_core_key_iv"}, {o_core_key, o_core_iv}, 0);
    chk({pfx, "_core_pt_aad"}, {o_core_pt, o_core_aad}, 0);
    chk({pfx, "_aad_size"}, o_core_aad_size, 0);
    chk({pfx, "_res_data"}, {o_res_cipher, o_res_tag}, 0);
    chk({pfx, "_res_id_err"}, {o_res_id, o_res_err}, 0);
    chk({pfx, "_job_cnt"}, o_job_cnt, 0);
  endtask

  // Wait for the grant of requester id, check launch, then check the result
  task automatic do_job(input int id, input int exp_lat, input bit exp_err,
                        input int bp, input bit keep);
    exp_t         e;
    int           n, lat;
    logic [127:0] hc, ht;
    logic [3:0]   hmisc;
    n = 0;
    @(negedge clk);
    while (o_gnt == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_seen", o_gnt != '0, 1);
    chk("gnt_onehot", o_gnt, 4'b0001 << id);
    chk("core_new", o_core_new, 1);
    chk("core_key", o_core_key, i_key[id*128 +: 128]);
    chk("core_iv", o_core_iv, i_iv[id*96 +: 96]);
    chk("core_pt_aad", {o_core_pt, o_core_aad}, {i_pt[id*128 +: 128], i_aad[id*128 +: 128]});
    chk("aad_size", o_core_aad_size, i_aad_en[id] ? 64'd128 : 64'd0);
    chk("pt_size", o_core_pt_size, 64'd128);
    if (!keep) i_req = '0;
    e.id = id;
    e.e  = exp_err;
    e.c  = exp_err ? 128'h0 : (cp_val ^ i_key[id*128 +: 128]);
    e.t  = exp_err ? 128'h0 : (tag_val ^ i_pt[id*128 +: 128]);
    q.push_back(e);
    @(negedge clk);
    lat = 1;
    chk("gnt_one_cycle", o_gnt, 0);
    chk("core_new_one_cycle", o_core_new, 0);
    while (!o_res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("res_valid_seen", o_res_valid, 1);
    chk("latency", lat, exp_lat);
    e = q.pop_front();
    chk("res_id", o_res_id, e.id);
    chk("res_cipher", o_res_cipher, e.c);
    chk("res_tag", o_res_tag, e.t);
    chk("res_err", o_res_err, e.e);
    chk("res_busy", o_busy, 1);
    hc = o_res_cipher;
    ht = o_res_tag;
    hmisc = {o_res_valid, o_res_id, o_res_err};
    repeat (bp) begin
      @(negedge clk);
      chk("bp_hold_data", {o_res_cipher, o_res_tag}, {hc, ht});
      chk("bp_hold_ctl", {o_res_valid, o_res_id, o_res_err}, hmisc);
      chk("bp_no_gnt", o_gnt, 0);
      chk("bp_busy", o_busy, 1);
      chk("bp_cnt", o_job_cnt, exp_cnt);
    end
    i_res_ready = 1'b1;
    @(posedge clk);
    #1;
    i_res_ready = 1'b0;
    exp_cnt++;
    chk("job_cnt", o_job_cnt, exp_cnt);
    chk("res_valid_drop", o_res_valid, 0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    reset_checks("rst");
    chk("rst_pt_size", o_core_pt_size, 64'd128);
    rst_n = 1'b1;

    for (int k = 0; k < NR; k++) begin
      i_key[k*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
      i_pt[k*128 +: 128]  = {$urandom, $urandom, $urandom, $urandom};
      i_aad[k*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
      i_iv[k*96 +: 96]    = {$urandom, $urandom, $urandom};
    end
    i_aad_en = 4'b1010;
    cp_val   = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    tag_val  = 128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff;

    // Round robin from reset, backpressure on the second job
    i_req = 4'b1111;
    do_job(0, 4, 0, 0, 1);
    do_job(1, 4, 0, 10, 1);
    do_job(2, 4, 0, 0, 1);
    do_job(3, 4, 0, 0, 1);
    do_job(0, 4, 0, 0, 0);

    // Single job with all-zero operands and known core answer
    i_key[127:0] = '0;
    i_iv[95:0]   = '0;
    i_pt[127:0]  = '0;
    i_aad[127:0] = '0;
    i_aad_en     = 4'b0000;
    cp_val  = 128'h0388dace60b6a392f328c2b971b2fe78;
    tag_val = 128'hab6e47d42cec13bdf53a67b21257bddf;
    i_req = 4'b0001;
    do_job(0, 4, 0, 0, 0);

    // Tag two cycles before cipher, repeated pulses after capture
    i_aad_en = 4'b0100;
    cp_val  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    tag_val = 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000;
    cp_dly = 4; tag_dly = 2; junk = 1'b1;
    i_req = 4'b0100;
    do_job(2, 6, 0, 0, 0);

    // Both readies in the same cycle
    junk = 1'b0; cp_dly = 3; tag_dly = 3;
    i_req = 4'b0001;
    do_job(0, 5, 0, 0, 0);

    // Timeout: core never answers
    cp_dly = -10; tag_dly = -10;
    i_req = 4'b0100;
    do_job(2, 17, 1, 0, 0);

    // Recovery with a stale ready in the first WAIT cycle
    stale = 1'b1; cp_dly = 3; tag_dly = 3;
    i_req = 4'b1000;
    do_job(3, 5, 0, 0, 0);
    stale = 1'b0;

    // Reset in the middle of WAIT
    cp_dly = -10; tag_dly = -10;
    i_req = 4'b0100;
    n = 0;
    @(negedge clk);
    while (o_gnt == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mid_gnt_seen", o_gnt, 4'b0100);
    i_req = '0;
    repeat (5) @(negedge clk);
    chk("mid_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    cp_dly = 2; tag_dly = 2;
    i_req = 4'b0010;
    do_job(1, 4, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gcm_job_scheduler.md
Name: gcm_job_scheduler

Overview:
- Round-robin scheduler that shares the single gcm_aes core among NUM_REQ requesters.
- Arbitrates pending jobs and latches the winner's key/IV/AAD/plaintext onto the core operand bus.
- Pulses the core's new-instance input, collects the ciphertext and tag, and returns them with the requester ID on a valid/ready result port.
- Sits between the requester fabric and gcm_aes, replacing the static all-zero tie-offs in the top-level wrapper.

Parameters:
- NUM_REQ, 4: number of requesters; range 2..8.
- TIMEOUT_CYC, 1024: cycles allowed in WAIT before a job is aborted with an error.
- CNT_W, 16: width of the completed-job counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  NUM_REQ  per-requester job pending; held until grant
- i_iv  in  NUM_REQ*96  IVs; requester k occupies bits [k*96 +: 96]
- i_key  in  NUM_REQ*128  cipher keys, same packing
- i_pt  in  NUM_REQ*128  plaintext blocks
- i_aad  in  NUM_REQ*128  AAD blocks
- i_aad_en  in  NUM_REQ  1 = AAD block present (aad_size 128), 0 = none (aad_size 0)
- o_gnt  out  NUM_REQ  one-hot, one-cycle grant pulse; operands are latched that cycle
- o_core_new  out  1  to gcm_aes i_new_instance
- o_core_iv  out  96  latched IV
- o_core_key  out  128  latched key
- o_core_pt  out  128  latched plaintext
- o_core_aad  out  128  latched AAD
- o_core_pt_size  out  64  constant 128
- o_core_aad_size  out  64  128 or 0, from the latched i_aad_en
- i_core_cp_ready  in  1  gcm_aes o_cp_ready
- i_core_cipher  in  128  gcm_aes o_cipher_text
- i_core_tag_ready  in  1  gcm_aes o_tag_ready
- i_core_tag  in  128  gcm_aes o_tag
- o_res_valid  out  1  result available
- i_res_ready  in  1  result consumer ready
- o_res_id  out  $clog2(NUM_REQ)  requester index of the result
- o_res_cipher  out  128  ciphertext
- o_res_tag  out  128  tag
- o_res_err  out  1  1 = timeout abort; cipher and tag are zero
- o_busy  out  1  state != IDLE
- o_job_cnt  out  CNT_W  completed results (ok or err); wraps

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; core operand registers 0.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
  - Reset mid-job abandons the job with no result; the core is restarted by the next o_core_new.
- States:
  - IDLE: on any i_req bit at a clock edge, grant the first requester found searching from pointer+1 with modulo wrap.
    - Same edge: latch operands and ID, set pointer=winner, o_gnt=onehot(winner) for one cycle, go to LAUNCH.
    - No request: stay in IDLE.
  - LAUNCH: o_core_new=1 for exactly one cycle; clear cp_got/tag_got and the timeout counter; go to WAIT.
  - WAIT:
    - The first WAIT cycle ignores core ready inputs, so stale readies from the previous job are masked.
    - From the second cycle, i_core_cp_ready=1 with cp_got=0 captures i_core_cipher and sets cp_got. i_core_tag_ready likewise captures the tag.
    - Both readies in the same cycle capture both.
    - Later ready pulses after capture are ignored.
    - When cp_got and tag_got are both set, go to RESP with err=0.
    - Counter increments every WAIT cycle. Reaching TIMEOUT_CYC-1 without both captures goes to RESP with err=1 and zeroed cipher/tag.
    - Completion on the same cycle as timeout counts as success.
  - RESP:
    - o_res_valid=1; id, cipher, tag and err are stable while valid and !ready.
    - On valid & i_res_ready: o_job_cnt++, go to IDLE.
- Operand outputs hold their latched values from grant until the next grant.
- Arbitration:
  - Requests are sampled only in IDLE.
  - Dropping i_req before grant withdraws the job.
  - i_req held after grant starts a new job.
- Latency: request seen at edge t → o_gnt and LAUNCH in cycle t+1 → o_core_new in cycle t+1 → earliest o_res_valid 4 cycles after grant when the core is ready immediately.

Test Plan:
- Single job: i_req=0001, i_key/iv/pt=0, i_aad_en=0, core model answers cipher 0x0388dace60b6a392f328c2b971b2fe78 and tag 0xab6e47d42cec13bdf53a67b21257bddf → o_gnt=0001 for one cycle; o_core_new pulses once; o_core_aad_size=0; result id=0, err=0 with those values; o_job_cnt=1.
- Round robin: i_req=1111 held for 4 jobs → grant order 0,1,2,3, then 0 again; exactly one o_gnt bit per job.
- Order and simultaneity: model returns the tag 2 cycles before the cipher, then in a later job returns both in the same cycle → correct capture both times; result asserted once per job.
- Backpressure: i_res_ready=0 for 10 cycles → o_res_valid and data stable; no new grant; o_busy=1; job_cnt increments only on the handshake.
- Timeout: model never readies, TIMEOUT_CYC=16 → o_res_err=1, cipher/tag zero after 16 WAIT cycles; the next job succeeds; a stale ready high during the new job's first WAIT cycle is ignored.
- Reset mid-WAIT: rst_n low for 1 cycle → all outputs 0 immediately; after release, i_req=0010 is granted and o_res_id=1.
